// File: rtl/bus_mem_ctrl.sv
// bus_mem_ctrl: word-RAM bus slave with programmable wait states and sticky error flag
module bus_mem_ctrl #(
  parameter int MEM_WORDS = 4096,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_LATENCY = 1,
  parameter INIT_FILE = "",
  parameter logic [31:0] OOR_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wmask,
  input  logic        bus_ren,
  input  logic        bus_wen,
  output logic [31:0] bus_rdata,
  output logic        bus_done,
  output logic        bus_err,
  output logic        busy
);
  localparam int IW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, next;
  logic [15:0] cnt, cnt_next, lat;
  logic [IW-1:0] r_idx, c_idx;
  logic [31:0] r_wdata, c_wdata;
  logic [3:0] r_wmask, c_wmask;
  logic r_write, r_oor, r_both, c_write, c_oor, c_both;
  logic idle, req, enter_done, unused;
  logic [31:0] mem [MEM_WORDS];
  assign unused = ^bus_addr[1:0];
  assign bus_done = state == DONE;
  assign busy = state != IDLE;
  // In IDLE the request fields come straight off the bus (so a 1-cycle latency can commit on the accept edge); afterwards the latched copy is used
  always_comb begin
    idle = state == IDLE;
    req = bus_ren | bus_wen;
    c_idx = idle ? bus_addr[IW+1:2] : r_idx;
    c_wdata = idle ? bus_wdata : r_wdata;
    c_wmask = idle ? bus_wmask : r_wmask;
    c_write = idle ? bus_wen : r_write;
    c_both = idle ? bus_ren & bus_wen : r_both;
    c_oor = idle ? {2'b00, bus_addr[31:2]} >= 32'(MEM_WORDS) : r_oor;
    lat = c_write ? 16'(WRITE_LATENCY) : 16'(READ_LATENCY);
    next = idle ? (req ? (lat == 16'd1 ? DONE : WAIT) : IDLE)
         : state == WAIT ? (cnt == 16'd1 ? DONE : WAIT) : IDLE;
    cnt_next = idle ? (req ? lat - 16'd1 : cnt) : state == WAIT ? cnt - 16'd1 : cnt;
    enter_done = next == DONE;
  end
  // FSM state, request latch, read data and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      r_idx <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_write <= 1'b0;
      r_oor <= 1'b0;
      r_both <= 1'b0;
      bus_rdata <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= next;
      cnt <= cnt_next;
      if (idle && req) begin
        r_idx <= c_idx;
        r_wdata <= c_wdata;
        r_wmask <= c_wmask;
        r_write <= c_write;
        r_oor <= c_oor;
        r_both <= c_both;
      end
      if (enter_done && !c_write) bus_rdata <= c_oor ? OOR_RDATA : mem[c_idx];
      if (enter_done && (c_oor || c_both)) bus_err <= 1'b1;
    end
  end
  // RAM write commits lane-wise on the edge entering DONE; no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (enter_done && c_write && !c_oor)
      for (int b = 0; b < 4; b++)
        if (c_wmask[b]) mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_bus_mem_ctrl.sv
// tb_bus_mem_ctrl: randomized bench for two bus_mem_ctrl instances against a transaction-level model
module tb_bus_mem_ctrl;
  localparam int MW = 256;
  logic clk = 0, rst = 1;
  logic [31:0] addr [2], wdata [2], rdata_o [2];
  logic [3:0] wmask [2];
  logic ren [2], wen [2], done_o [2], err_o [2], busy_o [2];
  int total = 0, bad = 0, cyc = 0;
  bit pend [2], m_err [2], w_l [2], both_l [2];
  int due [2];
  logic [31:0] m_rd [2], wa_l [2], wd_l [2];
  logic [3:0] m_l [2];
  logic [31:0] mm [2][MW];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bus_mem_ctrl #(.MEM_WORDS(MW), .READ_LATENCY(g == 0 ? 1 : 4), .WRITE_LATENCY(g == 0 ? 1 : 2)) dut (
      .clk(clk), .rst(rst), .bus_addr(addr[g]), .bus_wdata(wdata[g]), .bus_wmask(wmask[g]),
      .bus_ren(ren[g]), .bus_wen(wen[g]), .bus_rdata(rdata_o[g]), .bus_done(done_o[g]),
      .bus_err(err_o[g]), .busy(busy_o[g]));
  end

  initial forever #5 clk = ~clk;

  function automatic int lat(int u, logic w);
    return u == 0 ? 1 : (w ? 2 : 4);
  endfunction

  task automatic chk(string nm, int u, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s u%0d got=%h want=%h t=%0t", nm, u, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request accepted at an edge completes LATENCY edges later; one turnaround edge follows
  task automatic model_step();
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        pend[u] = 0; m_rd[u] = 0; m_err[u] = 0;
      end
    end else begin
      cyc++;
      for (int u = 0; u < 2; u++) begin
        if (pend[u] && cyc == due[u] + 1) pend[u] = 0;
        else if (!pend[u] && (ren[u] || wen[u])) begin
          pend[u] = 1; w_l[u] = wen[u]; both_l[u] = ren[u] & wen[u];
          wa_l[u] = {2'b00, addr[u][31:2]}; wd_l[u] = wdata[u]; m_l[u] = wmask[u];
          due[u] = cyc - 1 + lat(u, wen[u]);
        end
        if (pend[u] && cyc == due[u]) begin
          if (w_l[u]) begin
            if (wa_l[u] < MW)
              for (int b = 0; b < 4; b++)
                if (m_l[u][b]) mm[u][wa_l[u]][8*b +: 8] = wd_l[u][8*b +: 8];
          end else m_rd[u] = wa_l[u] < MW ? mm[u][wa_l[u]] : 32'hDEADBEEF;
          if (wa_l[u] >= MW || both_l[u]) m_err[u] = 1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Every-cycle comparison of both instances against the model
  initial forever begin
    @(negedge clk);
    if (!rst)
      for (int u = 0; u < 2; u++) begin
        chk("done", u, 32'(done_o[u]), 32'(pend[u] && cyc == due[u]));
        chk("busy", u, 32'(busy_o[u]), 32'(pend[u]));
        chk("err", u, 32'(err_o[u]), 32'(m_err[u]));
        chk("rdata", u, rdata_o[u], m_rd[u]);
      end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  task automatic txn(input int u, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, input bit scramble, output int lt);
    @(negedge clk);
    addr[u] = a; wdata[u] = d; wmask[u] = m; ren[u] = r; wen[u] = w;
    lt = -1;
    for (int k = 1; k <= 20 && lt < 0; k++) begin
      @(negedge clk);
      if (done_o[u]) lt = k;
      else if (scramble) begin
        addr[u] = $urandom; wdata[u] = $urandom; wmask[u] = 4'($urandom);
      end
    end
    ren[u] = 0; wen[u] = 0;
    if (lt < 0) begin
      total++; bad++;
      $display("FAIL done_timeout u%0d addr=%h", u, a);
    end
  endtask

  initial begin
    int lt, u, sel, gap;
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      addr[i] = 0; wdata[i] = 0; wmask[i] = 0; ren[i] = 0; wen[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_done", i, 32'(done_o[i]), 0);
      chk("rst_busy", i, 32'(busy_o[i]), 0);
      chk("rst_rdata", i, rdata_o[i], 0);
      chk("rst_err", i, 32'(err_o[i]), 0);
    end
    rst = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < MW; j++)
        txn(i, 0, 1, 32'(j * 4), j == 2 ? 32'h0 : j == 16 ? 32'h0BADF00D : $urandom, 4'hF, 0, lt);
    // reset mid-WAIT of a write aborts it
    txn(1, 1, 0, 32'h40, 0, 0, 0, lt);
    chk("t1_pre_rdata", 1, rdata_o[1], 32'h0BADF00D);
    @(negedge clk);
    addr[1] = 32'h40; wdata[1] = 32'h11223344; wmask[1] = 4'hF; wen[1] = 1;
    @(negedge clk);
    chk("t1_busy_wait", 1, 32'(busy_o[1]), 1);
    #2 rst = 1;
    #1;
    wen[1] = 0;
    chk("t1_async_done", 1, 32'(done_o[1]), 0);
    chk("t1_async_busy", 1, 32'(busy_o[1]), 0);
    chk("t1_async_rdata", 1, rdata_o[1], 0);
    chk("t1_async_err", 1, 32'(err_o[1]), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    txn(1, 1, 0, 32'h40, 0, 0, 0, lt);
    chk("t1_ram_kept", 1, rdata_o[1], 32'h0BADF00D);
    // latency 1 write then read
    txn(0, 0, 1, 32'h100, 32'hCAFEBABE, 4'hF, 0, lt);
    chk("t2_wlat", 0, 32'(lt), 1);
    txn(0, 1, 0, 32'h100, 0, 0, 0, lt);
    chk("t2_rlat", 0, 32'(lt), 1);
    chk("t2_rdata", 0, rdata_o[0], 32'hCAFEBABE);
    txn(0, 0, 1, 32'h104, 32'h12345678, 4'hF, 0, lt);
    repeat (3) @(negedge clk);
    chk("t2_hold", 0, rdata_o[0], 32'hCAFEBABE);
    // byte lanes
    txn(0, 0, 1, 32'h8, 32'hAA00BB00, 4'b1010, 0, lt);
    txn(0, 1, 0, 32'h8, 0, 0, 0, lt);
    chk("t3_lanes_a", 0, rdata_o[0], 32'hAA00BB00);
    txn(0, 0, 1, 32'hB, 32'h000000CC, 4'b0001, 0, lt);
    txn(0, 1, 0, 32'h8, 0, 0, 0, lt);
    chk("t3_lanes_b", 0, rdata_o[0], 32'hAA00BBCC);
    // long read latency with bus inputs wandering after accept
    txn(1, 1, 0, 32'h104, 0, 0, 1, lt);
    chk("t4_rlat", 1, 32'(lt), 4);
    // out of range
    chk("t5_err_pre", 0, 32'(err_o[0]), 0);
    txn(0, 1, 0, 32'h400, 0, 0, 0, lt);
    chk("t5_oor_rdata", 0, rdata_o[0], 32'hDEADBEEF);
    chk("t5_oor_err", 0, 32'(err_o[0]), 1);
    txn(0, 0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, lt);
    txn(0, 1, 0, 32'h0, 0, 0, 0, lt);
    txn(0, 1, 0, 32'h8, 0, 0, 0, lt);
    chk("t5_no_alias", 0, rdata_o[0], 32'hAA00BBCC);
    chk("t5_err_sticky", 0, 32'(err_o[0]), 1);
    // ren & wen together
    chk("t6_err_pre", 1, 32'(err_o[1]), 0);
    txn(1, 1, 1, 32'h0, 32'h5, 4'hF, 0, lt);
    chk("t6_as_write_lat", 1, 32'(lt), 2);
    chk("t6_err", 1, 32'(err_o[1]), 1);
    txn(1, 1, 0, 32'h0, 0, 0, 0, lt);
    chk("t6_rdata", 1, rdata_o[1], 32'h5);
    // random fetch/load/store traffic
    for (int n = 0; n < 400; n++) begin
      u = $urandom_range(1, 0);
      sel = $urandom_range(9, 0);
      a = sel == 0 ? 32'h400 + $urandom_range(4000, 0) : sel == 1 ? $urandom : $urandom_range(1023, 0);
      sel = $urandom_range(19, 0);
      txn(u, sel < 9 || sel == 19, sel >= 9, a, $urandom, 4'($urandom), $urandom_range(1, 0) == 1, lt);
      gap = $urandom_range(2, 0);
      repeat (gap) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
